// File: rtl/seven_seg_scan_driver.sv
// ============================================================================
//  Module      : seven_seg_scan_driver
//  Description : Time-multiplexed hex driver for N digits on a shared 7-segment
//                bus, with leading-zero blanking and frame-aligned double buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit DIG_ACT_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dot_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lzb_en,
    output logic [6:0]            seg_out,
    output logic                  dot_out,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic                  frame_done
);

    localparam int c_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [c_PW-1:0]     c_PRESC_TC = c_PW'(SCAN_DIV - 1);
    localparam logic [c_PW-1:0]     c_BLANK    = c_PW'(BLANK_CYCLES);
    localparam logic [6:0]          c_SEG_POL  = {7{SEG_ACT_LOW}};
    localparam logic [N_DIGITS-1:0] c_DIG_POL  = {N_DIGITS{DIG_ACT_LOW}};

    // Active-high {a,b,c,d,e,f,g} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    logic [c_PW-1:0]       r_presc;
    logic [c_IW-1:0]       w_idx;
    logic                  w_last_slot;
    logic                  w_presc_tc;
    logic                  w_boundary;

    logic [4*N_DIGITS-1:0] r_shadow_val;
    logic [N_DIGITS-1:0]   r_shadow_dot;
    logic [4*N_DIGITS-1:0] r_active_val;
    logic [N_DIGITS-1:0]   r_active_dot;

    logic [N_DIGITS-1:0]   w_lz_blank;
    logic                  w_zero_above;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [3:0]            w_nib;
    logic                  w_cur_dot;
    logic                  w_cur_vis;
    logic                  w_show;
    logic [6:0]            w_seg;

    assign w_presc_tc = (r_presc == c_PRESC_TC);
    assign w_boundary = w_presc_tc & w_last_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_presc_tc) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // A single-digit display has no index register; every slot ends a frame.
    if (N_DIGITS == 1) begin : g_idx_single
        assign w_idx       = '0;
        assign w_last_slot = 1'b1;
    end else begin : g_idx_multi
        logic [c_IW-1:0] r_idx;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_idx <= '0;
            end else if (w_presc_tc) begin
                r_idx <= w_last_slot ? '0 : r_idx + c_IW'(1);
            end
        end

        assign w_idx       = r_idx;
        assign w_last_slot = (r_idx == c_IW'(N_DIGITS - 1));
    end

    // A load coinciding with the boundary bypasses the shadow so it is not lost a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dot <= '0;
            r_active_val <= '0;
            r_active_dot <= '0;
        end else begin
            if (load) begin
                r_shadow_val <= value_in;
                r_shadow_dot <= dot_in;
            end
            if (w_boundary) begin
                r_active_val <= load ? value_in : r_shadow_val;
                r_active_dot <= load ? dot_in   : r_shadow_dot;
            end
        end
    end

    // Walk from the most significant nibble down; digit 0 is never blanked.
    always_comb begin
        w_lz_blank   = '0;
        w_zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_active_val[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_lz_blank[i] = lzb_en & w_zero_above;
            end
        end
    end

    always_comb begin
        w_nib     = '0;
        w_cur_dot = 1'b0;
        w_cur_vis = 1'b0;
        w_onehot  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_idx == c_IW'(i)) begin
                w_nib       = r_active_val[4*i +: 4];
                w_cur_dot   = r_active_dot[i];
                w_cur_vis   = digit_en[i] & ~w_lz_blank[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_show = (r_presc >= c_BLANK) & w_cur_vis;
    assign w_seg  = hex_to_seg(w_nib);

    // Polarity is applied by XOR so that "off" is simply the polarity constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= c_SEG_POL;
            dot_out    <= SEG_ACT_LOW;
            dig_sel    <= c_DIG_POL;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= (w_show ? w_seg : 7'h00) ^ c_SEG_POL;
            dot_out    <= (w_show & w_cur_dot) ^ SEG_ACT_LOW;
            dig_sel    <= (w_show ? w_onehot : '0) ^ c_DIG_POL;
            frame_done <= w_boundary;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
// ============================================================================
//  Module      : tb_seven_seg_scan_driver
//  Description : Directed bench for seven_seg_scan_driver (4 digits, 4-cycle
//                slots, 1 blank cycle, active-low segments and selects).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_driver;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] value_in = '0;
    logic        load     = 1'b0;
    logic [3:0]  dot_in   = '0;
    logic [3:0]  digit_en = 4'hF;
    logic        lzb_en   = 1'b0;
    logic [6:0]  seg_out;
    logic        dot_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    seven_seg_scan_driver #(
        .N_DIGITS    (4),
        .SCAN_DIV    (4),
        .BLANK_CYCLES(1),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .load      (load),
        .dot_in    (dot_in),
        .digit_en  (digit_en),
        .lzb_en    (lzb_en),
        .seg_out   (seg_out),
        .dot_out   (dot_out),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one 16-cycle frame; digit i expectations sit at seg_e[7i+:7],
    // dot_e[i], dig_e[4i+:4]. Loads are issued after ticks ld_tick and ld_tick+1.
    task automatic run_frame(input string name, input logic [27:0] seg_e,
                             input logic [3:0] dot_e, input logic [15:0] dig_e,
                             input int ld_tick, input logic [15:0] va,
                             input logic [15:0] vb);
        for (int t = 1; t <= 16; t++) begin
            int s;
            s = (t - 1) / 4;
            tick();
            if ((t - 1) % 4 == 0) begin
                check($sformatf("%s t%0d blank seg", name, t), 32'(seg_out), 32'h7F);
                check($sformatf("%s t%0d blank dot", name, t), 32'(dot_out), 32'h1);
                check($sformatf("%s t%0d blank dig", name, t), 32'(dig_sel), 32'hF);
            end else begin
                check($sformatf("%s t%0d seg", name, t), 32'(seg_out), 32'(seg_e[7*s +: 7]));
                check($sformatf("%s t%0d dot", name, t), 32'(dot_out), 32'(dot_e[s]));
                check($sformatf("%s t%0d dig", name, t), 32'(dig_sel), 32'(dig_e[4*s +: 4]));
            end
            check($sformatf("%s t%0d frame_done", name, t), 32'(frame_done), 32'(t == 16));
            if (t == ld_tick) begin
                value_in = va;
                load     = 1'b1;
            end else if (t == ld_tick + 1) begin
                value_in = vb;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        tick();
        tick();
        check("reset seg", 32'(seg_out), 32'h7F);
        check("reset dot", 32'(dot_out), 32'h1);
        check("reset dig", 32'(dig_sel), 32'hF);
        check("reset frame_done", 32'(frame_done), 32'h0);

        // 1234 lands in the shadow on the first edge after release.
        value_in = 16'h1234;
        load     = 1'b1;
        rst_n    = 1'b1;
        run_frame("f0 zeros", {4{7'h01}}, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE}, 99, '0, '0);

        lzb_en   = 1'b1;
        value_in = 16'h0005;
        load     = 1'b1;
        run_frame("f1 1234", {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF,
                  {4'h7, 4'hB, 4'hD, 4'hE}, 99, '0, '0);

        value_in = 16'h0000;
        load     = 1'b1;
        run_frame("f2 0005 lzb", {7'h7F, 7'h7F, 7'h7F, 7'h24}, 4'hF,
                  {4'hF, 4'hF, 4'hF, 4'hE}, 99, '0, '0);

        // Mid-frame loads must not disturb this frame; the last one wins next frame.
        run_frame("f3 0000 lzb", {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF,
                  {4'hF, 4'hF, 4'hF, 4'hE}, 5, 16'hABCD, 16'hFFFF);

        lzb_en = 1'b0;
        dot_in = 4'b0011;
        // Load after tick 15 is captured on the boundary edge itself.
        run_frame("f4 FFFF", {4{7'h38}}, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE},
                  15, 16'h1234, 16'h1234);

        digit_en = 4'b1010;
        run_frame("f5 1234 en1010", {7'h4F, 7'h7F, 7'h06, 7'h7F}, 4'b1101,
                  {4'h7, 4'hF, 4'hD, 4'hF}, 99, '0, '0);

        digit_en = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        check("pre-reset digit2 seg", 32'(seg_out), 32'h12);
        check("pre-reset digit2 dig", 32'(dig_sel), 32'hB);

        #2;
        rst_n = 1'b0;
        #1;
        check("async reset seg", 32'(seg_out), 32'h7F);
        check("async reset dot", 32'(dot_out), 32'h1);
        check("async reset dig", 32'(dig_sel), 32'hF);
        check("async reset frame_done", 32'(frame_done), 32'h0);
        tick();
        rst_n = 1'b1;
        run_frame("post-reset f0", {4{7'h01}}, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE}, 99, '0, '0);
        run_frame("post-reset f1", {4{7'h01}}, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE}, 99, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
